// File: rtl/flr_axis_gate.sv
// AXI-S TX gate: drops whole packets whose target PF/VF is held in FLR and
// forwards all other packets through a 2-entry skid buffer.
module flr_axis_gate #(
  parameter int TDATA_W    = 512,
  parameter int NUM_PF     = 1,
  parameter int NUM_VF     = 1,
  parameter int PF_W       = 3,
  parameter int VF_W       = 11,
  parameter int PF_LSB     = 160,
  parameter int VF_LSB     = 163,
  parameter int VFA_BIT    = 174,
  parameter int DROP_CNT_W = 16
) (
  input  logic                     clk_sys,
  input  logic                     rst_n_sys,
  input  logic [NUM_PF-1:0]        pf_flr_rst_n,
  input  logic [NUM_PF*NUM_VF-1:0] vf_flr_rst_n,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [TDATA_W-1:0]       s_tdata,
  input  logic [TDATA_W/8-1:0]     s_tkeep,
  input  logic                     s_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [TDATA_W-1:0]       m_tdata,
  output logic [TDATA_W/8-1:0]     m_tkeep,
  output logic                     m_tlast,
  input  logic                     drop_clr,
  output logic [DROP_CNT_W-1:0]    drop_cnt,
  output logic                     drop_busy
);

  localparam int KEEP_W = TDATA_W / 8;
  localparam int ENT_W  = TDATA_W + KEEP_W + 1;

  typedef enum logic [1:0] {ST_SOP, ST_PASS, ST_DROP} state_t;

  state_t                state_q, state_d;
  logic [ENT_W-1:0]      mem_q [2];
  logic [ENT_W-1:0]      mem_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic                  s_tready_q, s_tready_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [PF_W-1:0] pf;
  logic [VF_W-1:0] vf;
  logic            vfa;
  logic            pf_hit_rst, vf_hit_rst, in_rst;
  logic            accept, push, pop, drop_evt;

  assign pf     = s_tdata[PF_LSB +: PF_W];
  assign vf     = s_tdata[VF_LSB +: VF_W];
  assign vfa    = s_tdata[VFA_BIT];
  assign accept = s_tvalid && s_tready_q;
  assign pop    = m_tvalid && m_tready;

  // Out-of-range PF/VF numbers never match a loop index, so they pass.
  always_comb begin
    pf_hit_rst = 1'b0;
    vf_hit_rst = 1'b0;
    for (int p = 0; p < NUM_PF; p++) begin
      if (pf == PF_W'(p)) pf_hit_rst = ~pf_flr_rst_n[p];
      for (int v = 0; v < NUM_VF; v++) begin
        if (pf == PF_W'(p) && vf == VF_W'(v)) vf_hit_rst = ~vf_flr_rst_n[p*NUM_VF + v];
      end
    end
    in_rst = vfa ? vf_hit_rst : pf_hit_rst;
  end

  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    drop_evt = 1'b0;
    case (state_q)
      ST_SOP: begin
        if (accept) begin
          if (in_rst) begin
            drop_evt = 1'b1;
            state_d  = s_tlast ? ST_SOP : ST_DROP;
          end else begin
            push    = 1'b1;
            state_d = s_tlast ? ST_SOP : ST_PASS;
          end
        end
      end
      ST_PASS: begin
        if (accept) begin
          push = 1'b1;
          if (s_tlast) state_d = ST_SOP;
        end
      end
      ST_DROP: begin
        if (accept && s_tlast) state_d = ST_SOP;
      end
      default: state_d = ST_SOP;
    endcase
  end

  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !pop)      occ_d = occ_q + 2'd1;
    else if (!push && pop) occ_d = occ_q - 2'd1;
    if (push) begin
      mem_d[wr_ptr_q] = {s_tlast, s_tkeep, s_tdata};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    // Ready is registered from next occupancy, so m_tready never reaches s_tready.
    s_tready_d = (state_d == ST_DROP) || (occ_d != 2'd2);
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_clr)                                  drop_cnt_d = '0;
    else if (drop_evt && (drop_cnt_q != '1))       drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_sys or negedge rst_n_sys) begin
    if (!rst_n_sys) begin
      state_q    <= ST_SOP;
      occ_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      s_tready_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      s_tready_q <= s_tready_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    mem_q <= mem_d;
  end

  assign s_tready                  = s_tready_q;
  assign m_tvalid                  = (occ_q != 2'd0);
  assign {m_tlast, m_tkeep, m_tdata} = mem_q[rd_ptr_q];
  assign drop_cnt                  = drop_cnt_q;
  assign drop_busy                 = (state_q == ST_DROP);

endmodule

// File: tb/tb_flr_axis_gate.sv
// Scoreboard bench for flr_axis_gate: forwarded beats are queued at input
// handshake and compared in order at output handshake.
module tb_flr_axis_gate;

  localparam int TDATA_W = 512;
  localparam int KEEP_W  = TDATA_W / 8;
  localparam int NUM_PF  = 1;
  localparam int NUM_VF  = 2;
  localparam int CNT_W   = 4;
  localparam int ENT_W   = TDATA_W + KEEP_W + 1;

  logic                     clk_sys = 1'b0;
  logic                     rst_n_sys = 1'b0;
  logic [NUM_PF-1:0]        pf_flr_rst_n = '1;
  logic [NUM_PF*NUM_VF-1:0] vf_flr_rst_n = '1;
  logic                     s_tvalid = 1'b0;
  logic                     s_tready;
  logic [TDATA_W-1:0]       s_tdata = '0;
  logic [KEEP_W-1:0]        s_tkeep = '0;
  logic                     s_tlast = 1'b0;
  logic                     m_tvalid;
  logic                     m_tready = 1'b1;
  logic [TDATA_W-1:0]       m_tdata;
  logic [KEEP_W-1:0]        m_tkeep;
  logic                     m_tlast;
  logic                     drop_clr = 1'b0;
  logic [CNT_W-1:0]         drop_cnt;
  logic                     drop_busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  bit chk_full = 1'b0;
  bit bp_done  = 1'b0;
  logic [ENT_W-1:0] exp_q[$];

  flr_axis_gate #(
    .TDATA_W(TDATA_W), .NUM_PF(NUM_PF), .NUM_VF(NUM_VF), .DROP_CNT_W(CNT_W)
  ) dut (
    .clk_sys(clk_sys), .rst_n_sys(rst_n_sys),
    .pf_flr_rst_n(pf_flr_rst_n), .vf_flr_rst_n(vf_flr_rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .drop_clr(drop_clr), .drop_cnt(drop_cnt), .drop_busy(drop_busy)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  // Output monitor: scoreboard pop, hold-stable check and full-skid ready check.
  logic             prev_stall = 1'b0;
  logic [ENT_W-1:0] prev_beat  = '0;
  always @(negedge clk_sys) begin
    logic [ENT_W-1:0] cur;
    logic [ENT_W-1:0] exp;
    cur = {m_tlast, m_tkeep, m_tdata};
    if (!rst_n_sys) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (m_tvalid !== 1'b1 || cur !== prev_beat) begin
          n_errors++;
          $display("FAIL hold_stable: got valid=%0b last=%0b, required valid=1 and unchanged beat", m_tvalid, m_tlast);
        end
      end
      if (chk_full && exp_q.size() >= 2) begin
        n_checks++;
        if (s_tready !== 1'b0) begin
          n_errors++;
          $display("FAIL ready_when_full: got s_tready=%0b, required 0", s_tready);
        end
      end
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        n_checks++;
        n_out++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_beat: got beat tlast=%0b data[31:0]=%h, required no output", m_tlast, m_tdata[31:0]);
        end else begin
          exp = exp_q.pop_front();
          if (cur !== exp) begin
            n_errors++;
            $display("FAIL out_beat: got last=%0b data[31:0]=%h, required last=%0b data[31:0]=%h",
                     m_tlast, m_tdata[31:0], exp[ENT_W-1], exp[31:0]);
          end else begin
            $display("out beat %0d: last=%0b data[31:0]=%h", n_out, m_tlast, m_tdata[31:0]);
          end
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = cur;
    end
  end

  function automatic logic [TDATA_W-1:0] rnd_data();
    logic [TDATA_W-1:0] d;
    for (int i = 0; i < TDATA_W/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [TDATA_W-1:0] mk_hdr(input int pf, input int vf, input bit vfa);
    logic [TDATA_W-1:0] d;
    logic [31:0] pfv, vfv;
    d   = rnd_data();
    pfv = pf;
    vfv = vf;
    d[160 +: 3]  = pfv[2:0];
    d[163 +: 11] = vfv[10:0];
    d[174]       = vfa;
    return d;
  endfunction

  // Drives one beat from posedge+1; returns 1 time unit after its transfer edge.
  task automatic send_beat(input logic [TDATA_W-1:0] d, input bit last, input bit fwd,
                           input int exp_busy, input bit exp_rdy_now);
    logic [KEEP_W-1:0] k;
    int w;
    k = {$urandom, $urandom};
    s_tdata = d; s_tkeep = k; s_tlast = last; s_tvalid = 1'b1;
    @(negedge clk_sys);
    if (exp_rdy_now) begin
      n_checks++;
      if (s_tready !== 1'b1) begin
        n_errors++;
        $display("FAIL ready_now: got s_tready=%0b, required 1", s_tready);
      end
    end
    w = 0;
    while (s_tready !== 1'b1 && w < 200) begin
      @(negedge clk_sys);
      w++;
    end
    if (w >= 200) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_timeout: got s_tready=0 for 200 cycles, required 1");
      s_tvalid = 1'b0;
      return;
    end
    if (exp_busy >= 0) begin
      n_checks++;
      if (drop_busy !== exp_busy[0]) begin
        n_errors++;
        $display("FAIL drop_busy: got %0b, required %0d", drop_busy, exp_busy);
      end
    end
    @(posedge clk_sys);
    if (fwd) exp_q.push_back({last, k, d});
    $display("in beat: last=%0b fwd=%0b data[31:0]=%h", last, fwd, d[31:0]);
    #1 s_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int pf, input int vf, input bit vfa, input int nbeats, input bit fwd);
    for (int b = 0; b < nbeats; b++) begin
      send_beat(b == 0 ? mk_hdr(pf, vf, vfa) : rnd_data(), b == nbeats-1, fwd,
                fwd ? 0 : (b == 0 ? 0 : 1), !fwd);
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk_sys);
      w++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d beats outstanding, required 0", exp_q.size());
    end
    @(posedge clk_sys); #1;
  endtask

  task automatic check_cnt(input int exp, input string tag);
    n_checks++;
    if (drop_cnt !== CNT_W'(exp)) begin
      n_errors++;
      $display("FAIL drop_cnt_%s: got %0d, required %0d", tag, drop_cnt, exp);
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk_sys); #1 drop_clr = 1'b1;
    @(posedge clk_sys); #1 drop_clr = 1'b0;
    check_cnt(0, "clr");
  endtask

  task automatic test_reset();
    #13;
    n_checks += 4;
    if (m_tvalid !== 1'b0) begin n_errors++; $display("FAIL rst_m_tvalid: got %0b, required 0", m_tvalid); end
    if (s_tready !== 1'b0) begin n_errors++; $display("FAIL rst_s_tready: got %0b, required 0", s_tready); end
    if (drop_cnt !== '0)   begin n_errors++; $display("FAIL rst_drop_cnt: got %0d, required 0", drop_cnt); end
    if (drop_busy !== 1'b0) begin n_errors++; $display("FAIL rst_drop_busy: got %0b, required 0", drop_busy); end
    @(negedge clk_sys) rst_n_sys = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
  endtask

  task automatic test_pass();
    send_beat(mk_hdr(0, 0, 0), 1'b0, 1'b1, 0, 1'b1);
    n_checks++;
    if (m_tvalid !== 1'b1) begin
      n_errors++;
      $display("FAIL pass_latency: got m_tvalid=%0b one cycle after SOP, required 1", m_tvalid);
    end
    send_beat(rnd_data(), 1'b0, 1'b1, 0, 1'b0);
    send_beat(rnd_data(), 1'b1, 1'b1, 0, 1'b0);
    wait_drain();
    check_cnt(0, "pass");
  endtask

  task automatic test_pf_drop();
    pf_flr_rst_n[0] = 1'b0;
    send_pkt(0, 0, 1'b0, 4, 1'b0);
    wait_drain();
    check_cnt(1, "pf_drop");
    n_checks++;
    if (drop_busy !== 1'b0) begin n_errors++; $display("FAIL busy_after_drop: got %0b, required 0", drop_busy); end
    pf_flr_rst_n[0] = 1'b1;
  endtask

  task automatic test_vf_drop();
    pulse_clr();
    vf_flr_rst_n[1] = 1'b0;
    send_pkt(0, 1, 1'b1, 2, 1'b0);
    send_pkt(0, 0, 1'b1, 2, 1'b1);
    send_pkt(0, 1, 1'b1, 1, 1'b0);
    send_pkt(0, 0, 1'b1, 3, 1'b1);
    wait_drain();
    check_cnt(2, "vf_drop");
    vf_flr_rst_n[1] = 1'b1;
  endtask

  task automatic test_out_of_range();
    pulse_clr();
    pf_flr_rst_n[0] = 1'b0;
    vf_flr_rst_n    = '0;
    send_pkt(5, 0, 1'b0, 2, 1'b1);
    send_pkt(0, 7, 1'b1, 1, 1'b1);
    send_pkt(0, 0, 1'b1, 1, 1'b0);
    wait_drain();
    check_cnt(1, "oor");
    pf_flr_rst_n[0] = 1'b1;
    vf_flr_rst_n    = '1;
  endtask

  task automatic test_mid_flr();
    pulse_clr();
    send_beat(mk_hdr(0, 0, 0), 1'b0, 1'b1, 0, 1'b1);
    pf_flr_rst_n[0] = 1'b0;
    for (int b = 1; b < 5; b++) send_beat(rnd_data(), b == 4, 1'b1, 0, 1'b0);
    send_pkt(0, 0, 1'b0, 2, 1'b0);
    wait_drain();
    check_cnt(1, "mid_flr");
    pf_flr_rst_n[0] = 1'b1;
  endtask

  task automatic test_back_to_back();
    int out0;
    out0    = n_out;
    bp_done = 1'b0;
    chk_full = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(mk_hdr(0, 0, 0), 1'b1, 1'b1, 0, 1'b0);
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk_sys);
          #1 m_tready = ~m_tready;
        end
      end
    join
    m_tready = 1'b1;
    wait_drain();
    chk_full = 1'b0;
    n_checks++;
    if (n_out - out0 != 8) begin
      n_errors++;
      $display("FAIL bp_count: got %0d beats, required 8", n_out - out0);
    end
  endtask

  task automatic test_counter();
    pulse_clr();
    pf_flr_rst_n[0] = 1'b0;
    for (int i = 0; i < 17; i++) send_pkt(0, 0, 1'b0, 1, 1'b0);
    @(posedge clk_sys); #1;
    check_cnt(15, "saturate");
    drop_clr = 1'b1;
    send_pkt(0, 0, 1'b0, 1, 1'b0);
    drop_clr = 1'b0;
    check_cnt(0, "clr_with_drop");
    send_pkt(0, 0, 1'b0, 1, 1'b0);
    @(posedge clk_sys); #1;
    check_cnt(1, "after_clr");
    pf_flr_rst_n[0] = 1'b1;
  endtask

  task automatic test_reset_mid();
    m_tready = 1'b0;
    send_beat(mk_hdr(0, 0, 0), 1'b0, 1'b0, 0, 1'b1);
    send_beat(rnd_data(), 1'b0, 1'b0, 0, 1'b0);
    rst_n_sys = 1'b0;
    #1;
    n_checks += 2;
    if (m_tvalid !== 1'b0) begin n_errors++; $display("FAIL rstmid_m_tvalid: got %0b, required 0", m_tvalid); end
    if (s_tready !== 1'b0) begin n_errors++; $display("FAIL rstmid_s_tready: got %0b, required 0", s_tready); end
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys) rst_n_sys = 1'b1;
    m_tready = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    send_pkt(0, 0, 1'b0, 1, 1'b1);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_pass();
    test_pf_drop();
    test_vf_drop();
    test_out_of_range();
    test_mid_flr();
    test_back_to_back();
    test_counter();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
